// File: rtl/adt7310_measure_fsm_pkg.sv
// Shared constants for the ADT7310 one-shot measurement sequencer:
// state encoding and the SPI command bytes it emits.
package adt7310_measure_fsm_pkg;

    localparam logic [3:0] ST_IDLE       = 4'd0;
    localparam logic [3:0] ST_START_PEND = 4'd1;
    localparam logic [3:0] ST_CFG_VAL    = 4'd2;
    localparam logic [3:0] ST_CFG_WAIT   = 4'd3;
    localparam logic [3:0] ST_CFG_DRAIN1 = 4'd4;
    localparam logic [3:0] ST_CFG_DRAIN2 = 4'd5;
    localparam logic [3:0] ST_CONV       = 4'd6;
    localparam logic [3:0] ST_RD1        = 4'd7;
    localparam logic [3:0] ST_RD2        = 4'd8;
    localparam logic [3:0] ST_RD_WAIT    = 4'd9;
    localparam logic [3:0] ST_GET0       = 4'd10;
    localparam logic [3:0] ST_GET_MSB    = 4'd11;
    localparam logic [3:0] ST_GET_LSB    = 4'd12;
    localparam logic [3:0] ST_DONE       = 4'd13;

    localparam logic [7:0] CMD_WR_CONFIG = 8'h08;
    localparam logic [7:0] CFG_ONESHOT   = 8'h20;
    localparam logic [7:0] CMD_RD_TEMP   = 8'h50;
    localparam logic [7:0] DUMMY         = 8'hFF;

endpackage

// File: rtl/adt7310_measure_fsm_timer.sv
// Loadable down-counter with a zero flag; holds at zero instead of wrapping.
// Preset takes priority over decrement.
module adt7310_measure_fsm_timer #(
    parameter int Width = 16
) (
    input  logic             Reset_n_i,
    input  logic             Clk_i,
    input  logic             Preset_i,
    input  logic             Enable_i,
    input  logic [Width-1:0] PresetVal_i,
    output logic             Zero_o
);

    logic [Width-1:0] count_q;
    logic [Width-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (Preset_i) begin
            count_d = PresetVal_i;
        end else if (Enable_i && (count_q != '0)) begin
            count_d = count_q - Width'(1);
        end
    end

    always_ff @(posedge Clk_i or negedge Reset_n_i) begin
        if (!Reset_n_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign Zero_o = (count_q == '0);

endmodule

// File: rtl/adt7310_measure_fsm.sv
// Runs one ADT7310 one-shot conversion per Start pulse through the SPI master
// FIFOs and returns the 16-bit temperature with a single-cycle Done.
module adt7310_measure_fsm
    import adt7310_measure_fsm_pkg::*;
#(
    parameter int DataWidth = 8
) (
    input  logic                   Reset_n_i,
    input  logic                   Clk_i,
    input  logic                   Start_i,
    output logic                   Done_o,
    output logic [DataWidth-1:0]   Byte0_o,
    output logic [DataWidth-1:0]   Byte1_o,
    output logic                   ADT7310CS_n_o,
    output logic [DataWidth-1:0]   SPI_Data_o,
    output logic                   SPI_Write_o,
    output logic                   SPI_ReadNext_o,
    input  logic [DataWidth-1:0]   SPI_Data_i,
    input  logic                   SPI_FIFOFull_i,
    input  logic                   SPI_FIFOEmpty_i,
    input  logic                   SPI_Transmission_i,
    input  logic [2*DataWidth-1:0] ParamCounterPreset_i
);

    logic [3:0]           state_q;
    logic [3:0]           state_d;
    logic [DataWidth-1:0] byte0_q;
    logic [DataWidth-1:0] byte0_d;
    logic [DataWidth-1:0] byte1_q;
    logic [DataWidth-1:0] byte1_d;
    logic                 timer_preset;
    logic                 timer_enable;
    logic                 timer_zero;

    adt7310_measure_fsm_timer #(
        .Width(2*DataWidth)
    ) u_timer (
        .Reset_n_i   (Reset_n_i),
        .Clk_i       (Clk_i),
        .Preset_i    (timer_preset),
        .Enable_i    (timer_enable),
        .PresetVal_i (ParamCounterPreset_i),
        .Zero_o      (timer_zero)
    );

    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can infer a latch.
    always_comb begin
        state_d        = state_q;
        byte0_d        = byte0_q;
        byte1_d        = byte1_q;
        ADT7310CS_n_o  = 1'b1;
        SPI_Data_o     = '0;
        SPI_Write_o    = 1'b0;
        SPI_ReadNext_o = 1'b0;
        Done_o         = 1'b0;
        timer_preset   = 1'b0;
        timer_enable   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (Start_i) begin
                    SPI_Data_o = DataWidth'(CMD_WR_CONFIG);
                    if (SPI_FIFOFull_i) begin
                        state_d = ST_START_PEND;
                    end else begin
                        ADT7310CS_n_o = 1'b0;
                        SPI_Write_o   = 1'b1;
                        state_d       = ST_CFG_VAL;
                    end
                end
            end
            // A start that hit a full TX FIFO is remembered here until it can issue.
            ST_START_PEND: begin
                SPI_Data_o = DataWidth'(CMD_WR_CONFIG);
                if (!SPI_FIFOFull_i) begin
                    ADT7310CS_n_o = 1'b0;
                    SPI_Write_o   = 1'b1;
                    state_d       = ST_CFG_VAL;
                end
            end
            ST_CFG_VAL: begin
                ADT7310CS_n_o = 1'b0;
                SPI_Data_o    = DataWidth'(CFG_ONESHOT);
                if (!SPI_FIFOFull_i) begin
                    SPI_Write_o = 1'b1;
                    state_d     = ST_CFG_WAIT;
                end
            end
            ST_CFG_WAIT: begin
                if (SPI_Transmission_i) begin
                    ADT7310CS_n_o = 1'b0;
                end else begin
                    state_d = ST_CFG_DRAIN1;
                end
            end
            ST_CFG_DRAIN1: begin
                if (!SPI_FIFOEmpty_i) begin
                    SPI_ReadNext_o = 1'b1;
                    state_d        = ST_CFG_DRAIN2;
                end
            end
            ST_CFG_DRAIN2: begin
                if (!SPI_FIFOEmpty_i) begin
                    SPI_ReadNext_o = 1'b1;
                    timer_preset   = 1'b1;
                    state_d        = ST_CONV;
                end
            end
            ST_CONV: begin
                if (!timer_zero) begin
                    timer_enable = 1'b1;
                end else begin
                    ADT7310CS_n_o = 1'b0;
                    SPI_Data_o    = DataWidth'(CMD_RD_TEMP);
                    if (!SPI_FIFOFull_i) begin
                        SPI_Write_o = 1'b1;
                        state_d     = ST_RD1;
                    end
                end
            end
            ST_RD1, ST_RD2: begin
                ADT7310CS_n_o = 1'b0;
                SPI_Data_o    = DataWidth'(DUMMY);
                if (!SPI_FIFOFull_i) begin
                    SPI_Write_o = 1'b1;
                    state_d     = (state_q == ST_RD1) ? ST_RD2 : ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                if (SPI_Transmission_i) begin
                    ADT7310CS_n_o = 1'b0;
                end else begin
                    state_d = ST_GET0;
                end
            end
            ST_GET0: begin
                if (!SPI_FIFOEmpty_i) begin
                    SPI_ReadNext_o = 1'b1;
                    state_d        = ST_GET_MSB;
                end
            end
            ST_GET_MSB: begin
                if (!SPI_FIFOEmpty_i) begin
                    SPI_ReadNext_o = 1'b1;
                    byte1_d        = SPI_Data_i;
                    state_d        = ST_GET_LSB;
                end
            end
            ST_GET_LSB: begin
                if (!SPI_FIFOEmpty_i) begin
                    SPI_ReadNext_o = 1'b1;
                    byte0_d        = SPI_Data_i;
                    state_d        = ST_DONE;
                end
            end
            ST_DONE: begin
                Done_o  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values computed above, independent of evaluation order.
    always_ff @(posedge Clk_i or negedge Reset_n_i) begin
        if (!Reset_n_i) begin
            state_q <= ST_IDLE;
            byte0_q <= '0;
            byte1_q <= '0;
        end else begin
            state_q <= state_d;
            byte0_q <= byte0_d;
            byte1_q <= byte1_d;
        end
    end

    assign Byte0_o = byte0_q;
    assign Byte1_o = byte1_q;

endmodule

// File: tb/tb_adt7310_measure_fsm.sv
// Directed bench for adt7310_measure_fsm with a small SPI master/FIFO model
// that echoes a queued response byte for every byte written.
module tb_adt7310_measure_fsm;

    localparam int BYTE_CYC = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        Start_i = 1'b0;
    logic        Done_o;
    logic [7:0]  Byte0_o;
    logic [7:0]  Byte1_o;
    logic        ADT7310CS_n_o;
    logic [7:0]  SPI_Data_o;
    logic        SPI_Write_o;
    logic        SPI_ReadNext_o;
    logic [7:0]  SPI_Data_i = 8'h00;
    logic        SPI_FIFOFull_i = 1'b0;
    logic        SPI_FIFOEmpty_i = 1'b1;
    logic        SPI_Transmission_i = 1'b0;
    logic [15:0] preset = 16'd0;

    always #5 clk = ~clk;

    adt7310_measure_fsm #(.DataWidth(8)) dut (
        .Reset_n_i            (rst_n),
        .Clk_i                (clk),
        .Start_i              (Start_i),
        .Done_o               (Done_o),
        .Byte0_o              (Byte0_o),
        .Byte1_o              (Byte1_o),
        .ADT7310CS_n_o        (ADT7310CS_n_o),
        .SPI_Data_o           (SPI_Data_o),
        .SPI_Write_o          (SPI_Write_o),
        .SPI_ReadNext_o       (SPI_ReadNext_o),
        .SPI_Data_i           (SPI_Data_i),
        .SPI_FIFOFull_i       (SPI_FIFOFull_i),
        .SPI_FIFOEmpty_i      (SPI_FIFOEmpty_i),
        .SPI_Transmission_i   (SPI_Transmission_i),
        .ParamCounterPreset_i (preset)
    );

    typedef struct {int cyc; logic [7:0] data; logic cs_n;} tx_t;
    typedef struct {int cyc; logic cs_n;} rn_t;

    tx_t        tx_log[$];
    rn_t        rn_log[$];
    logic [7:0] resp_q[$];
    logic [7:0] shift_q[$];
    logic [7:0] rx_q[$];
    int         bit_cnt = 0;
    int         cyc = 0;
    int         done_cnt = 0;
    int         done_cyc = 0;
    logic [7:0] done_b0 = 8'h00;
    logic [7:0] done_b1 = 8'h00;
    int         checks = 0;
    int         errors = 0;

    // Logs pre-edge outputs, then updates the SPI model just after the edge.
    always @(posedge clk) begin : monitor_model
        logic wr_l;
        logic rn_l;
        wr_l = SPI_Write_o;
        rn_l = SPI_ReadNext_o;
        if (SPI_Write_o) tx_log.push_back('{cyc, SPI_Data_o, ADT7310CS_n_o});
        if (SPI_ReadNext_o) rn_log.push_back('{cyc, ADT7310CS_n_o});
        if (Done_o) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
            done_b0  = Byte0_o;
            done_b1  = Byte1_o;
        end
        cyc = cyc + 1;
        #1;
        if (!rst_n) begin
            shift_q.delete();
            rx_q.delete();
            resp_q.delete();
            bit_cnt = 0;
        end else begin
            if (rn_l && rx_q.size() > 0) rx_q.delete(0);
            if (shift_q.size() > 0) begin
                bit_cnt = bit_cnt + 1;
                if (bit_cnt == BYTE_CYC) begin
                    rx_q.push_back(shift_q[0]);
                    shift_q.delete(0);
                    bit_cnt = 0;
                end
            end
            if (wr_l) begin
                if (resp_q.size() > 0) begin
                    shift_q.push_back(resp_q[0]);
                    resp_q.delete(0);
                end else begin
                    shift_q.push_back(8'h00);
                end
            end
        end
        SPI_Transmission_i = (shift_q.size() > 0);
        SPI_FIFOEmpty_i    = (rx_q.size() == 0);
        SPI_Data_i         = (rx_q.size() > 0) ? rx_q[0] : 8'h00;
    end

    task automatic clear_logs();
        tx_log.delete();
        rn_log.delete();
        done_cnt = 0;
    endtask

    task automatic load_resp(input logic [7:0] msb, input logic [7:0] lsb);
        resp_q.push_back(8'h00);
        resp_q.push_back(8'h00);
        resp_q.push_back(8'h00);
        resp_q.push_back(msb);
        resp_q.push_back(lsb);
    endtask

    task automatic pulse_start(output int s_cyc);
        @(posedge clk); #1;
        Start_i = 1'b1;
        s_cyc   = cyc;
        @(posedge clk); #1;
        Start_i = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        int start_cnt;
        start_cnt = done_cnt;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done_cnt != start_cnt) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_tx(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (tx_log.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_rn(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (rn_log.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #12;
        checks++; if (Done_o !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", Done_o); end
        checks++; if (Byte0_o !== 8'h00) begin errors++; $display("FAIL reset_byte0: got %h expected 00", Byte0_o); end
        checks++; if (Byte1_o !== 8'h00) begin errors++; $display("FAIL reset_byte1: got %h expected 00", Byte1_o); end
        checks++; if (ADT7310CS_n_o !== 1'b1) begin errors++; $display("FAIL reset_cs_n: got %b expected 1", ADT7310CS_n_o); end
        checks++; if (SPI_Write_o !== 1'b0 || SPI_ReadNext_o !== 1'b0) begin
            errors++; $display("FAIL reset_strobes: got write=%b readnext=%b expected 0/0", SPI_Write_o, SPI_ReadNext_o);
        end
        checks++; if (SPI_Data_o !== 8'h00) begin errors++; $display("FAIL reset_spi_data: got %h expected 00", SPI_Data_o); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic();
        logic [7:0] tx_exp [5] = '{8'h08, 8'h20, 8'h50, 8'hFF, 8'hFF};
        int s;
        bit ok;
        clear_logs();
        preset = 16'd3;
        load_resp(8'h0C, 8'h80);
        pulse_start(s);
        wait_done(300, ok);
        checks++; if (!ok) begin errors++; $display("FAIL basic_timeout: got no Done expected Done within 300 cycles"); end
        checks++; if (tx_log.size() !== 5) begin errors++; $display("FAIL basic_tx_count: got %0d expected 5", tx_log.size()); end
        checks++; if (rn_log.size() !== 5) begin errors++; $display("FAIL basic_rn_count: got %0d expected 5", rn_log.size()); end
        if (tx_log.size() == 5 && rn_log.size() == 5) begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (tx_log[i].data !== tx_exp[i] || tx_log[i].cs_n !== 1'b0) begin
                    errors++; $display("FAIL basic_tx%0d: got data=%h cs_n=%b expected data=%h cs_n=0", i, tx_log[i].data, tx_log[i].cs_n, tx_exp[i]);
                end
            end
            checks++; if (tx_log[0].cyc !== s || tx_log[1].cyc !== s + 1) begin
                errors++; $display("FAIL basic_cfg_timing: got cycles %0d,%0d expected %0d,%0d", tx_log[0].cyc, tx_log[1].cyc, s, s + 1);
            end
            for (int i = 0; i < 5; i++) begin
                checks++; if (rn_log[i].cs_n !== 1'b1) begin errors++; $display("FAIL basic_rn%0d_cs_n: got %b expected 1", i, rn_log[i].cs_n); end
            end
            checks++; if (tx_log[2].cyc - rn_log[1].cyc !== 4) begin
                errors++; $display("FAIL basic_conv_len: got %0d expected 4", tx_log[2].cyc - rn_log[1].cyc);
            end
            checks++; if (tx_log[3].cyc !== tx_log[2].cyc + 1 || tx_log[4].cyc !== tx_log[2].cyc + 2) begin
                errors++; $display("FAIL basic_rd_timing: got %0d,%0d expected %0d,%0d", tx_log[3].cyc, tx_log[4].cyc, tx_log[2].cyc + 1, tx_log[2].cyc + 2);
            end
            checks++; if (done_cyc !== rn_log[4].cyc + 1) begin
                errors++; $display("FAIL basic_done_cycle: got %0d expected %0d", done_cyc, rn_log[4].cyc + 1);
            end
        end
        checks++; if (done_b1 !== 8'h0C || done_b0 !== 8'h80) begin
            errors++; $display("FAIL basic_done_bytes: got %h%h expected 0c80", done_b1, done_b0);
        end
        repeat (3) @(negedge clk);
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL basic_done_width: got %0d Done cycles expected 1", done_cnt); end
        checks++; if (Byte1_o !== 8'h0C || Byte0_o !== 8'h80 || ADT7310CS_n_o !== 1'b1) begin
            errors++; $display("FAIL basic_hold: got bytes=%h%h cs_n=%b expected 0c80 cs_n=1", Byte1_o, Byte0_o, ADT7310CS_n_o);
        end
    endtask

    task automatic test_preset0();
        int s;
        bit ok;
        clear_logs();
        preset = 16'd0;
        load_resp(8'h19, 8'h40);
        pulse_start(s);
        wait_done(300, ok);
        checks++; if (!ok) begin errors++; $display("FAIL p0_timeout: got no Done expected Done within 300 cycles"); end
        checks++; if (tx_log.size() !== 5 || rn_log.size() !== 5) begin
            errors++; $display("FAIL p0_counts: got tx=%0d rn=%0d expected 5/5", tx_log.size(), rn_log.size());
        end else begin
            checks++; if (tx_log[2].data !== 8'h50 || tx_log[2].cyc - rn_log[1].cyc !== 1) begin
                errors++; $display("FAIL p0_rd_cmd: got data=%h delay=%0d expected 50 delay=1", tx_log[2].data, tx_log[2].cyc - rn_log[1].cyc);
            end
        end
        checks++; if (done_b1 !== 8'h19 || done_b0 !== 8'h40) begin
            errors++; $display("FAIL p0_bytes: got %h%h expected 1940", done_b1, done_b0);
        end
    endtask

    task automatic test_tx_stall();
        int s;
        bit ok;
        // Stall on the configuration value write
        clear_logs();
        preset = 16'd1;
        load_resp(8'h0A, 8'h55);
        pulse_start(s);
        SPI_FIFOFull_i = 1'b1;
        @(negedge clk);
        checks++; if (SPI_Write_o !== 1'b0 || SPI_Data_o !== 8'h20 || ADT7310CS_n_o !== 1'b0) begin
            errors++; $display("FAIL stall_cfg_hold: got write=%b data=%h cs_n=%b expected 0/20/0", SPI_Write_o, SPI_Data_o, ADT7310CS_n_o);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        SPI_FIFOFull_i = 1'b0;
        wait_done(300, ok);
        checks++; if (!ok) begin errors++; $display("FAIL stall_cfg_timeout: got no Done expected Done within 300 cycles"); end
        checks++; if (tx_log.size() !== 5) begin
            errors++; $display("FAIL stall_cfg_count: got %0d expected 5", tx_log.size());
        end else begin
            checks++; if (tx_log[1].data !== 8'h20 || tx_log[1].cyc !== s + 4) begin
                errors++; $display("FAIL stall_cfg_write: got data=%h cyc=%0d expected 20 cyc=%0d", tx_log[1].data, tx_log[1].cyc, s + 4);
            end
        end
        checks++; if (done_b1 !== 8'h0A || done_b0 !== 8'h55) begin
            errors++; $display("FAIL stall_cfg_bytes: got %h%h expected 0a55", done_b1, done_b0);
        end

        // Stall on the start cycle itself
        clear_logs();
        load_resp(8'h7F, 8'hF0);
        SPI_FIFOFull_i = 1'b1;
        pulse_start(s);
        @(posedge clk); #1;
        @(posedge clk); #1;
        SPI_FIFOFull_i = 1'b0;
        wait_done(300, ok);
        checks++; if (!ok) begin errors++; $display("FAIL stall_start_timeout: got no Done expected Done within 300 cycles"); end
        checks++; if (tx_log.size() !== 5) begin
            errors++; $display("FAIL stall_start_count: got %0d expected 5", tx_log.size());
        end else begin
            checks++; if (tx_log[0].data !== 8'h08 || tx_log[0].cyc !== s + 3 || tx_log[1].cyc !== s + 4) begin
                errors++; $display("FAIL stall_start_write: got data=%h cycs=%0d,%0d expected 08 cycs=%0d,%0d",
                                   tx_log[0].data, tx_log[0].cyc, tx_log[1].cyc, s + 3, s + 4);
            end
        end
        checks++; if (done_b1 !== 8'h7F || done_b0 !== 8'hF0) begin
            errors++; $display("FAIL stall_start_bytes: got %h%h expected 7ff0", done_b1, done_b0);
        end
    endtask

    task automatic test_ignored_start();
        int s;
        bit ok;
        clear_logs();
        preset = 16'd20;
        load_resp(8'h12, 8'h34);
        pulse_start(s);
        wait_rn(2, 200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL ign_conv_timeout: got %0d reads expected 2", rn_log.size()); end
        repeat (3) @(posedge clk);
        #1;
        Start_i = 1'b1;
        @(negedge clk);
        checks++; if (SPI_Write_o !== 1'b0) begin errors++; $display("FAIL ign_conv_write: got %b expected 0", SPI_Write_o); end
        @(posedge clk); #1;
        Start_i = 1'b0;
        wait_tx(5, 200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL ign_rd_timeout: got %0d writes expected 5", tx_log.size()); end
        @(posedge clk); #1;
        Start_i = 1'b1;
        @(posedge clk); #1;
        Start_i = 1'b0;
        wait_done(300, ok);
        checks++; if (!ok) begin errors++; $display("FAIL ign_done_timeout: got no Done expected Done within 300 cycles"); end
        repeat (40) @(negedge clk);
        checks++; if (done_cnt !== 1 || tx_log.size() !== 5) begin
            errors++; $display("FAIL ign_single: got done=%0d writes=%0d expected 1/5", done_cnt, tx_log.size());
        end
        checks++; if (Byte1_o !== 8'h12 || Byte0_o !== 8'h34) begin
            errors++; $display("FAIL ign_bytes: got %h%h expected 1234", Byte1_o, Byte0_o);
        end
    endtask

    task automatic test_reset_mid();
        int s;
        bit ok;
        clear_logs();
        preset = 16'd50;
        load_resp(8'h55, 8'hAA);
        pulse_start(s);
        wait_rn(2, 200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rstmid_conv_timeout: got %0d reads expected 2", rn_log.size()); end
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (ADT7310CS_n_o !== 1'b1 || Done_o !== 1'b0) begin
            errors++; $display("FAIL rstmid_ctrl: got cs_n=%b done=%b expected 1/0", ADT7310CS_n_o, Done_o);
        end
        checks++; if (Byte1_o !== 8'h00 || Byte0_o !== 8'h00) begin
            errors++; $display("FAIL rstmid_bytes: got %h%h expected 0000", Byte1_o, Byte0_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        clear_logs();
        preset = 16'd2;
        load_resp(8'h1C, 8'h08);
        pulse_start(s);
        wait_done(300, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rstmid_rerun_timeout: got no Done expected Done within 300 cycles"); end
        checks++; if (tx_log.size() !== 5 || done_b1 !== 8'h1C || done_b0 !== 8'h08) begin
            errors++; $display("FAIL rstmid_rerun: got writes=%0d bytes=%h%h expected 5 1c08", tx_log.size(), done_b1, done_b0);
        end
    endtask

    task automatic test_back_to_back();
        int s;
        bit ok;
        clear_logs();
        preset = 16'd2;
        load_resp(8'h0C, 8'h80);
        load_resp(8'h01, 8'h90);
        pulse_start(s);
        wait_done(300, ok);
        checks++; if (!ok) begin errors++; $display("FAIL b2b_first_timeout: got no Done expected Done within 300 cycles"); end
        Start_i = 1'b1;
        #1;
        checks++; if (SPI_Write_o !== 1'b1 || SPI_Data_o !== 8'h08 || ADT7310CS_n_o !== 1'b0) begin
            errors++; $display("FAIL b2b_accept: got write=%b data=%h cs_n=%b expected 1/08/0", SPI_Write_o, SPI_Data_o, ADT7310CS_n_o);
        end
        @(posedge clk); #1;
        Start_i = 1'b0;
        wait_tx(10, 200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL b2b_tx_timeout: got %0d writes expected 10", tx_log.size()); end
        checks++; if (Byte1_o !== 8'h0C || Byte0_o !== 8'h80) begin
            errors++; $display("FAIL b2b_hold: got %h%h expected 0c80", Byte1_o, Byte0_o);
        end
        wait_done(300, ok);
        checks++; if (!ok) begin errors++; $display("FAIL b2b_second_timeout: got no Done expected Done within 300 cycles"); end
        checks++; if (done_cnt !== 2 || done_b1 !== 8'h01 || done_b0 !== 8'h90) begin
            errors++; $display("FAIL b2b_second: got done=%0d bytes=%h%h expected 2 0190", done_cnt, done_b1, done_b0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_preset0();
        test_tx_stall();
        test_ignored_start();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
